// File: rtl/register_file_pkg.sv
// Shared datapath widths, flag bit positions and the PC next-value helper.
// Consumed by register_file, reg_en8, and the ALU / control unit.
package register_file_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 16;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  // Priority is load > write-low-byte > increment > hold. The increment wraps modulo 2^16.
  function automatic logic [ADDR_W-1:0] pc_next(
    input logic [ADDR_W-1:0] pc,
    input logic              load,
    input logic              write,
    input logic              inc,
    input logic [ADDR_W-1:0] direct,
    input logic [DATA_W-1:0] data
  );
    logic [ADDR_W-1:0] nxt;
    nxt = pc;
    if (load) begin
      nxt = direct;
    end else if (write) begin
      nxt = {pc[ADDR_W-1:DATA_W], data};
    end else if (inc) begin
      nxt = pc + 16'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/reg_en8.sv
// 8-bit load-enable register with an async active-low reset to RESET_VAL.
// It loads one cycle after the enabling edge and never stalls.
module reg_en8
  import register_file_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] data_q;

  // d is only looked at when en is high, so an undriven d cannot leak into the register.
  always_comb begin
    data_d = data_q;
    if (en) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= RESET_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/register_file.sv
// CPU architectural registers: ACC, X, Y, SP, IR, FLAGS, plus a 16-bit PC that drives addr_bus.
// Writes are visible one cycle after the enabling edge. The block has no backpressure, and all outputs come from flops.
module register_file
  import register_file_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter logic [DATA_W-1:0] RESET_SP = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              acc_write,
  input  logic              x_write,
  input  logic              y_write,
  input  logic              sp_write,
  input  logic              ir_write,
  input  logic              flags_write,
  input  logic              pc_write,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_direct,
  input  logic              pc_inc,
  output logic [DATA_W-1:0] acc_out,
  output logic [DATA_W-1:0] x_out,
  output logic [DATA_W-1:0] y_out,
  output logic [DATA_W-1:0] sp_out,
  output logic [DATA_W-1:0] ir_out,
  output logic [DATA_W-1:0] flags_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] addr_bus
);

  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_q;

  reg_en8 #(.RESET_VAL(8'h00)) u_acc (
    .clk(clk), .rst_n(reset), .en(acc_write), .d(data_in), .q(acc_out)
  );

  reg_en8 #(.RESET_VAL(8'h00)) u_x (
    .clk(clk), .rst_n(reset), .en(x_write), .d(data_in), .q(x_out)
  );

  reg_en8 #(.RESET_VAL(8'h00)) u_y (
    .clk(clk), .rst_n(reset), .en(y_write), .d(data_in), .q(y_out)
  );

  reg_en8 #(.RESET_VAL(RESET_SP)) u_sp (
    .clk(clk), .rst_n(reset), .en(sp_write), .d(data_in), .q(sp_out)
  );

  reg_en8 #(.RESET_VAL(8'h00)) u_ir (
    .clk(clk), .rst_n(reset), .en(ir_write), .d(data_in), .q(ir_out)
  );

  // FLAGS is stored byte-for-byte. Bit meanings are left to the ALU and control unit.
  reg_en8 #(.RESET_VAL(8'h00)) u_flags (
    .clk(clk), .rst_n(reset), .en(flags_write), .d(data_in), .q(flags_out)
  );

  always_comb begin
    pc_d = pc_next(pc_q, pc_load, pc_write, pc_inc, pc_direct, data_in);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_out   = pc_q;
  assign addr_bus = pc_q;

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
// Every expected value in the stimulus sequence is hand-computed.
module tb_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  data_in;
  logic        acc_write, x_write, y_write, sp_write, ir_write, flags_write;
  logic        pc_write, pc_load, pc_inc;
  logic [15:0] pc_direct;
  logic [7:0]  acc_out, x_out, y_out, sp_out, ir_out, flags_out;
  logic [15:0] pc_out, addr_bus;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  register_file dut (
    .clk(clk), .reset(reset), .data_in(data_in),
    .acc_write(acc_write), .x_write(x_write), .y_write(y_write),
    .sp_write(sp_write), .ir_write(ir_write), .flags_write(flags_write),
    .pc_write(pc_write), .pc_load(pc_load), .pc_direct(pc_direct), .pc_inc(pc_inc),
    .acc_out(acc_out), .x_out(x_out), .y_out(y_out), .sp_out(sp_out),
    .ir_out(ir_out), .flags_out(flags_out), .pc_out(pc_out), .addr_bus(addr_bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    acc_write = 0; x_write = 0; y_write = 0; sp_write = 0; ir_write = 0;
    flags_write = 0; pc_write = 0; pc_load = 0; pc_inc = 0;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    idle();
    data_in = 8'h00;
    pc_direct = 16'h0000;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("rst_acc", {8'h0, acc_out}, 16'h0000);
    chk("rst_sp", {8'h0, sp_out}, 16'h00FF);
    chk("rst_pc", pc_out, 16'h0000);
    chk("rst_addr", addr_bus, 16'h0000);

    step(); step();
    reset = 1'b1;
    step();

    data_in = 8'h5A; acc_write = 1; x_write = 1;
    chk("acc_old_before_edge", {8'h0, acc_out}, 16'h0000);
    step(); idle();
    chk("acc_5a", {8'h0, acc_out}, 16'h005A);
    chk("x_5a", {8'h0, x_out}, 16'h005A);
    chk("y_hold", {8'h0, y_out}, 16'h0000);
    chk("ir_hold", {8'h0, ir_out}, 16'h0000);
    chk("flags_hold", {8'h0, flags_out}, 16'h0000);
    chk("sp_hold", {8'h0, sp_out}, 16'h00FF);

    data_in = 8'hxx; pc_direct = 16'hxxxx;
    step();
    chk("x_in_acc", {8'h0, acc_out}, 16'h005A);
    chk("x_in_y", {8'h0, y_out}, 16'h0000);
    chk("x_in_pc", pc_out, 16'h0000);

    data_in = 8'hC3; y_write = 1; sp_write = 1; ir_write = 1;
    step(); idle();
    chk("y_c3", {8'h0, y_out}, 16'h00C3);
    chk("sp_c3", {8'h0, sp_out}, 16'h00C3);
    chk("ir_c3", {8'h0, ir_out}, 16'h00C3);
    chk("acc_keep", {8'h0, acc_out}, 16'h005A);

    pc_load = 1; pc_direct = 16'hFFFE;
    step(); idle();
    chk("pc_load_fffe", pc_out, 16'hFFFE);
    pc_inc = 1;
    step();
    chk("pc_ffff", pc_out, 16'hFFFF);
    chk("addr_ffff", addr_bus, 16'hFFFF);
    step(); idle();
    chk("pc_wrap", pc_out, 16'h0000);
    chk("addr_wrap", addr_bus, 16'h0000);

    pc_load = 1; pc_direct = 16'h1234; pc_inc = 1; pc_write = 1; data_in = 8'h77;
    step(); idle();
    chk("pc_prio_load", pc_out, 16'h1234);

    pc_write = 1; data_in = 8'hAB;
    step(); idle();
    chk("pc_write_lo", pc_out, 16'h12AB);
    pc_inc = 1;
    step(); idle();
    chk("pc_inc_12ac", pc_out, 16'h12AC);

    flags_write = 1; data_in = 8'h03;
    step(); idle();
    chk("flags_03", {8'h0, flags_out}, 16'h0003);

    pc_inc = 1;
    step();
    chk("pc_12ad", pc_out, 16'h12AD);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_flags", {8'h0, flags_out}, 16'h0000);
    chk("mid_rst_pc", pc_out, 16'h0000);
    chk("mid_rst_addr", addr_bus, 16'h0000);
    chk("mid_rst_acc", {8'h0, acc_out}, 16'h0000);
    chk("mid_rst_x", {8'h0, x_out}, 16'h0000);
    chk("mid_rst_ir", {8'h0, ir_out}, 16'h0000);
    chk("mid_rst_sp", {8'h0, sp_out}, 16'h00FF);

    idle();
    acc_write = 1; data_in = 8'h99; pc_load = 1; pc_direct = 16'h4321;
    step();
    chk("rst_block_acc", {8'h0, acc_out}, 16'h0000);
    chk("rst_block_pc", pc_out, 16'h0000);
    reset = 1'b1;
    step(); idle();
    chk("post_rst_acc", {8'h0, acc_out}, 16'h0099);
    chk("post_rst_pc", pc_out, 16'h4321);

    pc_direct = 16'hxxxx; pc_write = 1; data_in = 8'h10;
    step(); idle();
    chk("pc_write_xdirect", pc_out, 16'h4310);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
